// File: rtl/lane_pkg.sv
// Shared lane definitions: default lane count, value type and the cyclic next-enabled-lane search.
package lane_pkg;

    localparam int unsigned NUM_LANES = 9;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_LANES = 32;

    typedef logic [DATA_W-1:0] lane_data_t;

    // First set bit of mask strictly after cur, wrapping at n; returns cur itself when it is the only set bit.
    function automatic logic [4:0] next_enabled(
        input logic [4:0]           cur,
        input logic [MAX_LANES-1:0] mask,
        input int unsigned          n
    );
        logic [4:0] idx;
        logic [4:0] res;
        logic       found;
        idx   = cur;
        res   = cur;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < n) begin
                idx = (32'(idx) == n - 32'd1) ? 5'd0 : idx + 5'd1;
                if (!found && mask[idx]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with free-running wrapping pointers and a separate occupancy count.
module sync_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            din,
    output logic [DATA_W-1:0]            dout,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned LVW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [LVW-1:0]               level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVW'(1);
            2'b01:   level_d = level_q - LVW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level gates every read of it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/lane_dispatcher.sv
// Round-robin dispatcher: buffers a value stream and offers the head to one enabled lane at a time.
module lane_dispatcher #(
    parameter int unsigned NUM_LANES = lane_pkg::NUM_LANES,
    parameter int unsigned DATA_W    = lane_pkg::DATA_W,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_W-1:0]                   in_data,
    input  logic [NUM_LANES-1:0]                lane_en,
    output logic [NUM_LANES-1:0]                out_valid,
    input  logic [NUM_LANES-1:0]                out_ready,
    output logic [NUM_LANES-1:0][DATA_W-1:0]    out_data,
    output logic [$clog2(DEPTH+1)-1:0]          level,
    output logic [$clog2(NUM_LANES)-1:0]        cur_lane
);

    import lane_pkg::*;

    localparam int unsigned LW  = $clog2(NUM_LANES);
    localparam int unsigned LVW = $clog2(DEPTH+1);

    logic [LW-1:0]     cur_lane_q, cur_lane_d;
    logic [DATA_W-1:0] head;
    logic              push, pop, offer, hop;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (head),
        .level (level)
    );

    // No bypass: a full FIFO refuses even when a pop happens in the same cycle.
    assign in_ready = (level != LVW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign offer    = (level != '0) && lane_en[cur_lane_q];
    assign pop      = offer && out_ready[cur_lane_q];
    assign hop      = pop || (!lane_en[cur_lane_q] && (lane_en != '0));

    always_comb begin
        cur_lane_d = cur_lane_q;
        if (hop) cur_lane_d = LW'(next_enabled(5'(cur_lane_q), 32'(lane_en), NUM_LANES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_lane_q <= '0;
        else        cur_lane_q <= cur_lane_d;
    end

    // Only the pointed-at lane sees the head; every other slice reads as zero.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (offer && (cur_lane_q == LW'(k))) begin
                out_valid[k] = 1'b1;
                out_data[k]  = head;
            end
        end
    end

    assign cur_lane = cur_lane_q;

endmodule
